i2c_master_ctrl: RTL and testbench
==================================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: CLK_IN cycles per SCL quarter-period; legal range 2..255.
REQ-002 SHALL have port CLK_IN, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_N_IN, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port CMD_VALID, input, 1: command request.
REQ-005 SHALL have port CMD_READY, output, 1: command accepted in any cycle where CMD_VALID and CMD_READY are both 1.
REQ-006 SHALL have port CMD_RW, input, 1: 0 = write one byte, 1 = read one byte.
REQ-007 SHALL have port CMD_ADDR, input, 7: target slave address.
REQ-008 SHALL have port CMD_WDATA, input, 8: write payload.
REQ-009 SHALL have port RSP_VALID, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port RSP_RDATA, output, 8: read byte; valid with RSP_VALID.
REQ-011 SHALL have port RSP_NACK, output, 1: slave NACKed the address or write data; valid with RSP_VALID.
REQ-012 SHALL have port BUSY, output, 1: high from command acceptance through the RSP_VALID cycle.
REQ-013 SHALL have port SCL, inout, 1: open-drain; drives 0 or z, never 1.
REQ-014 SHALL have port SDA, inout, 1: open-drain; drives 0 or z, never 1.

Function
REQ-015 SHALL capture CMD_RW, CMD_ADDR and CMD_WDATA on acceptance; later input changes have no effect on the transaction.
REQ-016 SHALL assert CMD_READY only in IDLE; CMD_VALID outside IDLE is ignored.
REQ-017 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP, DONE.
REQ-018 SHALL follow these transitions: IDLE->START on accept; START->ADDR; ADDR->ADDR_ACK after 8 bits; ADDR_ACK->WDATA (ACK, RW=0), ->RDATA (ACK, RW=1), ->STOP (NACK); WDATA->WDATA_ACK after 8 bits; WDATA_ACK->STOP; RDATA->RDATA_ACK after 8 bits; RDATA_ACK->STOP; STOP->DONE; DONE->IDLE after 1 cycle.
REQ-019 SHALL divide every START, bit and STOP slot into 4 quarters of CLK_DIV cycles: Q0 and Q1 SCL low, Q2 and Q3 SCL released.
REQ-020 SHALL change SDA only at the start of Q0, except within START and STOP.
REQ-021 SHALL generate START with SDA released in Q0-Q1, pulled low from Q2, SCL released in Q1-Q3.
REQ-022 SHALL generate STOP with SDA low in Q0-Q1, released at the start of Q3, SCL released from Q2.
REQ-023 SHALL sample SDA at the first cycle of Q3 for ACK and read bits.
REQ-024 SHALL transmit the address byte as {CMD_ADDR, CMD_RW}, LSB first (RW bit first), to match the team's slave shift order.
REQ-025 SHALL transmit write data LSB first.
REQ-026 SHALL shift read data in LSB first: first received bit lands in RSP_RDATA[0].
REQ-027 SHALL release SDA during ADDR_ACK, WDATA_ACK and RDATA; SDA=1 sampled during an ACK slot means NACK.
REQ-028 SHALL release SDA in RDATA_ACK (master NACK, end of read); this is not an error.
REQ-029 SHALL complete a full transaction in 80*CLK_DIV cycles of activity (20 slots) and assert RSP_VALID in the DONE cycle immediately after.
REQ-030 SHALL complete an address-NACK transaction in 44*CLK_DIV cycles (11 slots), with RSP_NACK=1 and RSP_RDATA=0.
REQ-031 SHALL hold RSP_RDATA=0 for write transactions.
REQ-032 SHALL hold RSP_RDATA and RSP_NACK stable until the next RSP_VALID.
REQ-033 SHALL accept a new command at the earliest in the cycle after RSP_VALID.
REQ-034 SHALL NOT support clock stretching or multi-master arbitration; SCL is not sampled.

Reset
REQ-035 SHALL, with RESET_N_IN low, immediately (asynchronously) enter IDLE and release SCL and SDA.
REQ-036 SHALL, with RESET_N_IN low, drive CMD_READY=0, RSP_VALID=0, RSP_NACK=0, RSP_RDATA=0, BUSY=0, and clear all counters.
REQ-037 SHALL drive CMD_READY=1 from the first clock after RESET_N_IN deasserts.
REQ-038 SHALL abandon a transfer cut by reset: no STOP, no RSP_VALID.

Verification
REQ-039 Write, CLK_DIV=4, ADDR=7'h2A, WDATA=8'hA5, slave ACKs -> bus bits after START 0,0,1,0,1,0,1,0 then ACK, then 1,0,1,0,0,1,0,1, STOP; RSP_VALID 320 cycles after accept; RSP_NACK=0.
REQ-040 Read, ADDR=7'h2A, slave returns 8'h3C -> RSP_RDATA=8'h3C, RSP_NACK=0, master SDA released in the 9th data slot.
REQ-041 Write to an absent address, SDA pulled high -> STOP follows the address ACK slot; RSP_VALID 176 cycles after accept; RSP_NACK=1.
REQ-042 CMD_VALID held high across a transaction, payload changed mid-transfer -> exactly one accept; bus carries the original payload; second accept in the cycle after RSP_VALID.
REQ-043 RESET_N_IN pulsed low mid-WDATA -> SCL/SDA released in the same cycle, no RSP_VALID; next write completes normally.
REQ-044 Protocol monitor across all tests -> SDA never changes while SCL is high except at START/STOP; SCL/SDA never driven 1.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: each command becomes START, address byte, one data byte and STOP.
// SCL and SDA are open-drain. Every bus slot is four quarters of CLK_DIV clocks.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK_IN,
    input  logic       RESET_N_IN,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_RW,
    input  logic [6:0] CMD_ADDR,
    input  logic [7:0] CMD_WDATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_NACK,
    output logic       BUSY,
    inout  wire        SCL,
    inout  wire        SDA
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] q_cnt;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] wdata_q;
    logic [7:0] rx_shift;
    logic [7:0] rsp_rdata_q;
    logic       rw_q;
    logic       nack_q;
    logic       rsp_nack_q;
    logic       init_done;

    logic       scl_low;
    logic       sda_low;
    logic       sda_in;
    logic       accept;
    logic       on_bus;
    logic       q_last;
    logic       slot_end;
    logic       sample_pt;
    logic       last_bit;

    assign sda_in    = SDA;
    assign accept    = CMD_VALID && CMD_READY;
    assign on_bus    = (state != S_IDLE) && (state != S_DONE);
    assign q_last    = (q_cnt == 8'(CLK_DIV - 1));
    assign slot_end  = on_bus && (quarter == 2'd3) && q_last;
    assign sample_pt = on_bus && (quarter == 2'd3) && (q_cnt == 8'd0);
    assign last_bit  = (bit_cnt == 3'd7);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_START;
            S_START:     if (slot_end) state_nxt = S_ADDR;
            S_ADDR:      if (slot_end && last_bit) state_nxt = S_ADDR_ACK;
            S_ADDR_ACK: begin
                if (slot_end) begin
                    if (nack_q)    state_nxt = S_STOP;
                    else if (rw_q) state_nxt = S_RDATA;
                    else           state_nxt = S_WDATA;
                end
            end
            S_WDATA:     if (slot_end && last_bit) state_nxt = S_WDATA_ACK;
            S_WDATA_ACK: if (slot_end) state_nxt = S_STOP;
            S_RDATA:     if (slot_end && last_bit) state_nxt = S_RDATA_ACK;
            S_RDATA_ACK: if (slot_end) state_nxt = S_STOP;
            S_STOP:      if (slot_end) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Slot timing, shift registers and the response registers, which only
    // change on the STOP->DONE edge so they stay stable between responses.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            q_cnt       <= '0;
            quarter     <= '0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            wdata_q     <= '0;
            rx_shift    <= '0;
            rsp_rdata_q <= '0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            rsp_nack_q  <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            init_done <= 1'b1;

            if (on_bus) begin
                if (q_last) begin
                    q_cnt   <= '0;
                    quarter <= quarter + 2'd1;
                end else begin
                    q_cnt <= q_cnt + 8'd1;
                end
            end else begin
                q_cnt   <= '0;
                quarter <= '0;
            end

            if (accept) begin
                rw_q     <= CMD_RW;
                wdata_q  <= CMD_WDATA;
                tx_shift <= {CMD_ADDR, CMD_RW};
                rx_shift <= '0;
                nack_q   <= 1'b0;
                bit_cnt  <= '0;
            end

            if (sample_pt) begin
                case (state)
                    S_ADDR_ACK, S_WDATA_ACK: nack_q   <= nack_q | sda_in;
                    S_RDATA:                 rx_shift <= {sda_in, rx_shift[7:1]};
                    default: ;
                endcase
            end

            if (slot_end) begin
                case (state)
                    S_ADDR, S_WDATA: begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                    S_RDATA:    bit_cnt  <= bit_cnt + 3'd1;
                    S_ADDR_ACK: tx_shift <= wdata_q;
                    S_STOP: begin
                        rsp_rdata_q <= rx_shift;
                        rsp_nack_q  <= nack_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus pins decode from registered state only, so reset releases them at once.
    always_comb begin
        scl_low   = 1'b0;
        sda_low   = 1'b0;
        CMD_READY = (state == S_IDLE) && init_done;
        BUSY      = (state != S_IDLE);
        RSP_VALID = (state == S_DONE);
        RSP_RDATA = rsp_rdata_q;
        RSP_NACK  = rsp_nack_q;
        case (state)
            S_START: begin
                scl_low = (quarter == 2'd0);
                sda_low = quarter[1];
            end
            S_ADDR, S_WDATA: begin
                scl_low = ~quarter[1];
                sda_low = ~tx_shift[0];
            end
            S_ADDR_ACK, S_WDATA_ACK, S_RDATA, S_RDATA_ACK: begin
                scl_low = ~quarter[1];
            end
            S_STOP: begin
                scl_low = ~quarter[1];
                sda_low = (quarter != 2'd3);
            end
            default: ;
        endcase
    end

    assign SCL = scl_low ? 1'b0 : 1'bz;
    assign SDA = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus decoder plus behavioural slave on the wires, and a
// transaction-level model that predicts the decoded symbol stream, latency and response.
module tb_i2c_master_ctrl;

    localparam int         CLK_DIV  = 4;
    localparam int         SYM_S    = 2;
    localparam int         SYM_P    = 3;
    localparam logic [6:0] SLV_ADDR = 7'h2A;

    logic       CLK_IN     = 1'b0;
    logic       RESET_N_IN = 1'b0;
    logic       CMD_VALID  = 1'b0;
    logic       CMD_RW     = 1'b0;
    logic [6:0] CMD_ADDR   = '0;
    logic [7:0] CMD_WDATA  = '0;
    logic       CMD_READY;
    logic       RSP_VALID;
    logic [7:0] RSP_RDATA;
    logic       RSP_NACK;
    logic       BUSY;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);

    logic       slv_low   = 1'b0;
    logic [7:0] slv_rdata = '0;
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .CLK_IN     (CLK_IN),
        .RESET_N_IN (RESET_N_IN),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_RW     (CMD_RW),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_WDATA  (CMD_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_NACK   (RSP_NACK),
        .BUSY       (BUSY),
        .SCL        (scl),
        .SDA        (sda)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc   = 0;
    int n_acc = 0;
    always @(posedge CLK_IN) begin
        cyc <= cyc + 1;
        if (RESET_N_IN && CMD_VALID && CMD_READY) n_acc <= n_acc + 1;
    end

    // Bus decoder and slave: SCL rise records the SDA bit, SDA edges with SCL high
    // are START/STOP; the slave updates its SDA drive just after each SCL fall.
    int         bus_q[$];
    logic       prev_scl  = 1'b1;
    logic       prev_sda  = 1'b1;
    logic       in_xfer   = 1'b0;
    int         rise_n    = 0;
    int         fall_n    = 0;
    logic [7:0] addr_byte = '0;

    function automatic logic slave_drive(input int n);
        logic acked;
        acked = (addr_byte[7:1] == SLV_ADDR);
        if (n == 9) return acked;
        if (acked && addr_byte[0] && n >= 10 && n <= 17) return !slv_rdata[n - 10];
        if (acked && !addr_byte[0] && n == 18) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge CLK_IN) begin
        prev_scl <= scl;
        prev_sda <= sda;
        if (!RESET_N_IN) begin
            in_xfer <= 1'b0;
            slv_low <= 1'b0;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            bus_q.push_back(SYM_S);
            in_xfer <= 1'b1;
            rise_n  <= 0;
            fall_n  <= 0;
            slv_low <= 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            bus_q.push_back(SYM_P);
            in_xfer <= 1'b0;
            slv_low <= 1'b0;
        end else if (!prev_scl && scl) begin
            bus_q.push_back(int'(sda));
            if (in_xfer && rise_n < 8) addr_byte[rise_n] <= sda;
            rise_n <= rise_n + 1;
        end else if (prev_scl && !scl && in_xfer) begin
            fall_n  <= fall_n + 1;
            slv_low <= slave_drive(fall_n + 1);
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transaction model: START slot clocks a 1 then START; address and data bits go
    // LSB first; an absent slave leaves the ACK slot high; STOP slot clocks a 0 then STOP.
    int         exp_q[$];
    int         exp_lat;
    logic       exp_nack;
    logic [7:0] exp_rdata;

    function automatic void model(input logic rw, input logic [6:0] addr,
                                  input logic [7:0] wdata, input logic [7:0] srd);
        logic [7:0] abyte;
        logic       present;
        abyte   = {addr, rw};
        present = (addr == SLV_ADDR);
        exp_q   = {};
        exp_q.push_back(1);
        exp_q.push_back(SYM_S);
        for (int i = 0; i < 8; i++) exp_q.push_back(int'(abyte[i]));
        exp_q.push_back(present ? 0 : 1);
        if (present) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(rw ? int'(srd[i]) : int'(wdata[i]));
            exp_q.push_back(rw ? 1 : 0);
        end
        exp_q.push_back(0);
        exp_q.push_back(SYM_P);
        exp_lat   = (present ? 20 : 11) * 4 * CLK_DIV;
        exp_nack  = !present;
        exp_rdata = (present && rw) ? srd : 8'h00;
    endfunction

    task automatic launch(input string name, input logic rw, input logic [6:0] addr,
                          input logic [7:0] wdata, output int t0);
        int n;
        CMD_RW    = rw;
        CMD_ADDR  = addr;
        CMD_WDATA = wdata;
        CMD_VALID = 1'b1;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 200) begin
            @(negedge CLK_IN);
            n++;
        end
        check($sformatf("%s ready_wait_ok", name), 32'(n < 200), 32'd1);
        @(negedge CLK_IN);
        t0 = cyc;
        check($sformatf("%s busy_after_accept", name), 32'(BUSY), 32'd1);
        check($sformatf("%s ready_low_after_accept", name), 32'(CMD_READY), 32'd0);
    endtask

    task automatic finish(input string name, input int t0, input int base);
        int n;
        n = 0;
        while (RSP_VALID !== 1'b1 && n < 2000) begin
            @(negedge CLK_IN);
            n++;
        end
        check($sformatf("%s rsp_wait_ok", name), 32'(n < 2000), 32'd1);
        check($sformatf("%s latency", name), 32'(cyc - t0), 32'(exp_lat));
        check($sformatf("%s rsp_nack", name), 32'(RSP_NACK), 32'(exp_nack));
        check($sformatf("%s rsp_rdata", name), 32'(RSP_RDATA), 32'(exp_rdata));
        check($sformatf("%s busy_in_rsp", name), 32'(BUSY), 32'd1);
        check($sformatf("%s n_symbols", name), 32'(bus_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < bus_q.size())
                check($sformatf("%s sym%0d", name, i), 32'(bus_q[base + i]), 32'(exp_q[i]));
        end
    endtask

    task automatic after_rsp(input string name);
        @(negedge CLK_IN);
        check($sformatf("%s rsp_one_cycle", name), 32'(RSP_VALID), 32'd0);
        check($sformatf("%s ready_after_rsp", name), 32'(CMD_READY), 32'd1);
        check($sformatf("%s idle_not_busy", name), 32'(BUSY), 32'd0);
        check($sformatf("%s nack_held", name), 32'(RSP_NACK), 32'(exp_nack));
        check($sformatf("%s rdata_held", name), 32'(RSP_RDATA), 32'(exp_rdata));
    endtask

    task automatic run_txn(input string name, input logic rw, input logic [6:0] addr,
                           input logic [7:0] wdata, input logic [7:0] srd);
        int t0;
        int base;
        model(rw, addr, wdata, srd);
        slv_rdata = srd;
        base = bus_q.size();
        launch(name, rw, addr, wdata, t0);
        CMD_VALID = 1'b0;
        CMD_RW    = $urandom_range(0, 1);
        CMD_ADDR  = 7'($urandom);
        CMD_WDATA = 8'($urandom);
        finish(name, t0, base);
        after_rsp(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0;
        int         base;
        int         acc0;
        int         k;
        logic       rv_seen;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] srd;

        repeat (3) @(negedge CLK_IN);
        check("reset cmd_ready", 32'(CMD_READY), 32'd0);
        check("reset rsp_valid", 32'(RSP_VALID), 32'd0);
        check("reset busy", 32'(BUSY), 32'd0);
        check("reset rsp_nack", 32'(RSP_NACK), 32'd0);
        check("reset rsp_rdata", 32'(RSP_RDATA), 32'd0);
        check("reset scl_released", 32'(scl), 32'd1);
        check("reset sda_released", 32'(sda), 32'd1);
        RESET_N_IN = 1'b1;
        #1;
        check("release ready_before_clock", 32'(CMD_READY), 32'd0);
        @(negedge CLK_IN);
        check("release ready_first_clock", 32'(CMD_READY), 32'd1);

        run_txn("wr_2a_a5", 1'b0, 7'h2A, 8'hA5, 8'h00);
        run_txn("rd_2a_3c", 1'b1, 7'h2A, 8'h00, 8'h3C);
        run_txn("wr_absent", 1'b0, 7'h13, 8'h5A, 8'h00);

        // Reset in the middle of the write data byte abandons the transfer.
        model(1'b0, SLV_ADDR, 8'hC3, 8'h00);
        launch("abort", 1'b0, SLV_ADDR, 8'hC3, t0);
        CMD_VALID = 1'b0;
        k = $urandom_range(162, 280);
        repeat (k) @(negedge CLK_IN);
        RESET_N_IN = 1'b0;
        #1;
        check("abort scl_released", 32'(scl), 32'd1);
        check("abort sda_released", 32'(sda), 32'd1);
        check("abort ready_low", 32'(CMD_READY), 32'd0);
        check("abort busy_low", 32'(BUSY), 32'd0);
        check("abort rsp_valid_low", 32'(RSP_VALID), 32'd0);
        check("abort nack_cleared", 32'(RSP_NACK), 32'd0);
        check("abort rdata_cleared", 32'(RSP_RDATA), 32'd0);
        repeat (3) @(negedge CLK_IN);
        RESET_N_IN = 1'b1;
        rv_seen = 1'b0;
        repeat (400) begin
            @(negedge CLK_IN);
            rv_seen = rv_seen | RSP_VALID;
        end
        check("abort no_rsp_valid", 32'(rv_seen), 32'd0);
        check("abort ready_again", 32'(CMD_READY), 32'd1);
        run_txn("wr_after_abort", 1'b0, 7'h2A, 8'h96, 8'h00);

        // CMD_VALID held high with the payload changed mid-transfer.
        acc0 = n_acc;
        slv_rdata = 8'hE1;
        model(1'b0, SLV_ADDR, 8'h0F, 8'hE1);
        base = bus_q.size();
        launch("hold_a", 1'b0, SLV_ADDR, 8'h0F, t0);
        repeat (40) @(negedge CLK_IN);
        CMD_RW    = 1'b1;
        CMD_WDATA = 8'h77;
        finish("hold_a", t0, base);
        check("hold single_accept", 32'(n_acc - acc0), 32'd1);
        model(1'b1, SLV_ADDR, 8'h77, 8'hE1);
        base = bus_q.size();
        @(negedge CLK_IN);
        check("hold second_accept_ready", 32'(CMD_READY), 32'd1);
        @(negedge CLK_IN);
        t0 = cyc;
        CMD_VALID = 1'b0;
        check("hold second_accepted", 32'(n_acc - acc0), 32'd2);
        finish("hold_b", t0, base);
        after_rsp("hold_b");

        for (int i = 0; i < 8; i++) begin
            rw    = 1'($urandom_range(0, 1));
            wdata = 8'($urandom);
            srd   = 8'($urandom);
            addr  = SLV_ADDR;
            if ($urandom_range(0, 2) == 0) begin
                addr = 7'($urandom);
                if (addr == SLV_ADDR) addr = addr ^ 7'h01;
            end
            run_txn($sformatf("rand%0d", i), rw, addr, wdata, srd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
